// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
package nibble_serial_addsub_pkg;

   localparam int unsigned NibbleW = 4;

   // Two-bit state encoding; StIllegal is never entered and recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRun     = 2'd1,
      StDone    = 2'd2,
      StIllegal = 2'd3
   } state_e;

   // Nibble index width: $clog2 of the nibble count, at least one bit.
   function automatic int unsigned idx_width(input int unsigned nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_addsub_adder4.sv
// Four-bit ripple-carry adder exposing the carry into and out of the MSB.
module nibble_serial_addsub_adder4
   import nibble_serial_addsub_pkg::*;
(
   input  logic [NibbleW-1:0] a_i,
   input  logic [NibbleW-1:0] b_i,
   input  logic               cin_i,
   output logic [NibbleW-1:0] s_o,
   output logic               c3_o,
   output logic               c4_o
);

   logic [NibbleW:0] carry;

   // Ripple the carry through each bit; c3 is the carry into bit 3.
   always_comb begin
      carry    = '0;
      s_o      = '0;
      carry[0] = cin_i;
      for (int i = 0; i < NibbleW; i++) begin
         s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign c3_o = carry[NibbleW-1];
   assign c4_o = carry[NibbleW];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-nibble two's-complement adder/subtractor. One nibble is processed per
// clock, LSB first, through a single shared 4-bit adder.
module nibble_serial_addsub
   import nibble_serial_addsub_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [NibbleW*NIBBLES-1:0]   a_i,
   input  logic [NibbleW*NIBBLES-1:0]   b_i,
   input  logic                         sub_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [NibbleW*NIBBLES-1:0]   result_o,
   output logic                         carry_out_o,
   output logic                         overflow_o,
   output logic                         zero_o,
   output logic                         busy_o
);

   localparam int unsigned W    = NibbleW * NIBBLES;
   localparam int unsigned IdxW = idx_width(NIBBLES);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   state_e state_q, state_d;

   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;        // already inverted for subtraction
   logic            carry_q, carry_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [W-1:0]    result_q, result_d;
   logic            carry_out_q, carry_out_d;
   logic            overflow_q, overflow_d;
   logic            zero_q, zero_d;

   logic               accept;
   logic               last_nib;
   logic [NibbleW-1:0] a_nib, b_nib, s_nib;
   logic               c3, c4;

   assign accept   = in_valid_i && (state_q == StIdle);
   assign last_nib = (idx_q == LastIdx);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> RUN -> DONE -> IDLE; the spare encoding recovers to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (in_valid_i) state_d = StRun;
         end
         StRun: begin
            if (last_nib) state_d = StDone;
         end
         StDone: begin
            // Returning to IDLE here means the next accept is at least one edge later.
            if (out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b1;
      case (state_q)
         StIdle: begin
            in_ready_o = 1'b1;
            busy_o     = 1'b0;
         end
         StDone:  out_valid_o = 1'b1;
         default: ;
      endcase
   end

   // Select the operand nibbles addressed by the current index.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IdxW'(i)) begin
            a_nib = a_q[i*NibbleW +: NibbleW];
            b_nib = b_q[i*NibbleW +: NibbleW];
         end
      end
   end

   nibble_serial_addsub_adder4 u_adder4 (
      .a_i   (a_nib),
      .b_i   (b_nib),
      .cin_i (carry_q),
      .s_o   (s_nib),
      .c3_o  (c3),
      .c4_o  (c4)
   );

   // Datapath next-state: load on accept, accumulate one nibble per RUN cycle.
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;

      if (accept) begin
         // Subtraction is A + ~B + 1: invert B once here, carry-in of 1 below.
         a_d         = a_i;
         b_d         = b_i ^ {W{sub_i}};
         carry_d     = sub_i;
         idx_d       = '0;
         result_d    = '0;
         carry_out_d = 1'b0;
         overflow_d  = 1'b0;
         zero_d      = 1'b0;
      end else if (state_q == StRun) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IdxW'(i)) result_d[i*NibbleW +: NibbleW] = s_nib;
         end
         carry_d = c4;
         idx_d   = idx_q + 1'b1;
         if (last_nib) begin
            carry_out_d = c4;
            overflow_d  = c3 ^ c4;
            zero_d      = (result_d == '0);
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
      end
   end

   assign result_o    = result_q;
   assign carry_out_o = carry_out_q;
   assign overflow_o  = overflow_q;
   assign zero_o      = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed and random bench for nibble_serial_addsub with NIBBLES=4.
module tb_nibble_serial_addsub;

   typedef struct packed {
      logic [15:0] result;
      logic        carry;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        carry_out;
   logic        overflow;
   logic        zero;
   logic        busy;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   nibble_serial_addsub #(.NIBBLES(4)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .sub_i       (sub),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .carry_out_o (carry_out),
      .overflow_o  (overflow),
      .zero_o      (zero),
      .busy_o      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Independent reference: full-width add of A and (possibly inverted) B.
   function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic ms);
      exp_t        r;
      logic [15:0] bb;
      logic [16:0] s;
      bb       = ms ? ~mb : mb;
      s        = {1'b0, ma} + {1'b0, bb} + {16'd0, ms};
      r.result = s[15:0];
      r.carry  = s[16];
      r.ovf    = (ma[15] == bb[15]) && (s[15] != ma[15]);
      r.zero   = (s[15:0] == 16'd0);
      return r;
   endfunction

   // Present a request, push its expectation, return 1ns after the accepting edge.
   task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       input exp_t e);
      int w;
      sb.push_back(e);
      a        = ta;
      b        = tb_;
      sub      = ts;
      in_valid = 1'b1;
      w        = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble the inputs: the block must have sampled them at acceptance.
      a        = 16'($urandom);
      b        = 16'($urandom);
      sub      = 1'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 100) check("valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic consume(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_result"}, 32'(result), 32'(e.result));
         check({tag, "_carry"}, 32'(carry_out), 32'(e.carry));
         check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
         check({tag, "_zero"}, 32'(zero), 32'(e.zero));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int          lat;
      logic [15:0] ra, rb;
      logic        rs;

      // Reset state.
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      #13;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1. Basic add and latency.
      send(16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0});
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_in_ready_low", 32'(in_ready), 32'd0);
      wait_valid(lat);
      check("t1_latency", 32'(lat), 32'd4);
      consume("t1");

      // 2. Signed overflow and zero/carry.
      send(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0});
      wait_valid(lat);
      consume("t2a");
      send(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1});
      wait_valid(lat);
      consume("t2b");

      // 3. Subtraction.
      send(16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0});
      wait_valid(lat);
      consume("t3a");
      send(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0});
      wait_valid(lat);
      consume("t3b");

      // 4. Backpressure: outputs hold, new requests ignored.
      send(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0, 1'b0});
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom);
         a        = 16'($urandom);
         b        = 16'($urandom);
         @(posedge clk);
         #1;
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_result", 32'(result), 32'h3333);
         check("t4_hold_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
         check("t4_in_ready_low", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      consume("t4");
      check("t4_idle_after", 32'(busy), 32'd0);

      // 5. Reset two cycles into RUN aborts the operation.
      send(16'hABCD, 16'h1357, 1'b0, model(16'hABCD, 16'h1357, 1'b0));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("t5_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      check("t5_result", 32'(result), 32'd0);
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0});
      wait_valid(lat);
      check("t5_latency", 32'(lat), 32'd4);
      consume("t5");

      // 6. Random operations with gaps on both sides.
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         ra        = 16'($urandom);
         rb        = 16'($urandom);
         rs        = 1'($urandom);
         out_ready = 1'($urandom);   // has no effect outside DONE
         send(ra, rb, rs, model(ra, rb, rs));
         out_ready = 1'b0;
         wait_valid(lat);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         consume("rnd");
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
